// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the Sobol encoder and decoder. The word is
// {exp[3:0], mant[11:0]} with no sign bit. The MSO is the most-significant-one
// position. It is rebuilt as exp + offset, and offsets below FP16_MIN_MSO cannot be represented.
package fp16_pkg;

  localparam int FP16_EXP_W   = 4;
  localparam int FP16_MANT_W  = 12;
  localparam int FP16_MIN_MSO = 11;
  localparam int FP16_SHIFT_W = 5;
  localparam int FP16_M_W     = 6;

  typedef struct packed {
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  typedef struct packed {
    logic                    err;
    logic [FP16_SHIFT_W-1:0] shift;
  } fp16_dec_t;

  // Map an exponent to a left-shift amount. An MSO outside 11..31 has no
  // 32-bit representation and is reported as an error with shift forced to 0.
  function automatic fp16_dec_t fp16_decode_exp(
    input logic [FP16_EXP_W-1:0] exp,
    input logic [FP16_M_W-1:0]   offset
  );
    logic [FP16_M_W-1:0] m;
    fp16_dec_t           d;
    m       = {2'b00, exp} + offset;
    d.err   = (m < FP16_M_W'(FP16_MIN_MSO)) || (m > FP16_M_W'(31));
    d.shift = d.err ? '0 : FP16_SHIFT_W'(m - FP16_M_W'(FP16_MIN_MSO));
    return d;
  endfunction

endpackage

// File: rtl/fp16_shift_unit.sv
// Combinational expansion of a 12-bit mantissa into a 32-bit magnitude.
// The shifter is a log-depth barrel shifter with one mux level per shift bit.
// Optional macro ROUND_HALF_EN: when it is defined, the bit just below the lowest kept mantissa bit
// is set. The result then sits at the midpoint of the truncated interval instead of its floor.
// Errored words always produce 0.
module fp16_shift_unit
  import fp16_pkg::*;
(
  input  logic [FP16_MANT_W-1:0]  mant,
  input  logic [FP16_SHIFT_W-1:0] shift,
  input  logic                    err,
  output logic [31:0]             result
);

  logic [31:0] stage [0:FP16_SHIFT_W];
  logic [31:0] shifted;

  assign stage[0] = {{(32-FP16_MANT_W){1'b0}}, mant};

  genvar gi;
  generate
    for (gi = 0; gi < FP16_SHIFT_W; gi++) begin : g_shift
      assign stage[gi+1] = shift[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
    end
  endgenerate

  assign shifted = stage[FP16_SHIFT_W];

`ifdef ROUND_HALF_EN
  // The value (1<<shift)>>1 is bit shift-1, and it is zero when shift is 0.
  // A shift of 0 therefore stays exact without any special case.
  logic [31:0] half;
  assign half   = (32'd1 << shift) >> 1;
  assign result = err ? 32'd0 : (shifted | half);
`else
  assign result = err ? 32'd0 : shifted;
`endif

endmodule

// File: rtl/fp16_to_int32.sv
// This block decodes a streaming FP16 word into a 32-bit unsigned integer through a 2-stage valid/ready pipeline.
// Stage 1 decodes the exponent. Stage 2 holds the barrel-shifted result and drives the outputs.
// err_cnt is a saturating count of errored results that have been handed to the consumer.
// Optional macro ROUND_HALF_EN (see fp16_shift_unit) adds midpoint reconstruction.
module fp16_to_int32
  import fp16_pkg::*;
#(
  parameter int MSO_OFFSET = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_fp16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_int32,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  fp16_t                   in_word;
  fp16_dec_t               in_dec;

  logic                    s1_valid;
  logic [FP16_MANT_W-1:0]  s1_mant;
  logic [FP16_SHIFT_W-1:0] s1_shift;
  logic                    s1_err;

  logic                    s2_valid;
  logic [31:0]             s2_data;
  logic                    s2_err;

  logic                    s1_ready;
  logic                    s2_ready;
  logic                    out_xfer;
  logic [31:0]             shift_result;
  logic [CNT_W-1:0]        cnt;

  assign in_word = fp16_t'(in_fp16);
  assign in_dec  = fp16_decode_exp(in_word.exp, FP16_M_W'(MSO_OFFSET));

  // A stage may load when it is empty or when its contents leave in the same cycle.
  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign out_xfer = s2_valid && out_ready;

  // Stage 1 captures the mantissa and the decoded shift/error of each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_shift <= '0;
      s1_err   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= in_word.mant;
        s1_shift <= in_dec.shift;
        s1_err   <= in_dec.err;
      end
    end
  end

  fp16_shift_unit u_shift (
    .mant   (s1_mant),
    .shift  (s1_shift),
    .err    (s1_err),
    .result (shift_result)
  );

  // Stage 2 holds the expanded result. It stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= shift_result;
        s2_err  <= s1_err;
      end
    end
  end

  // Count errored results on delivery. Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (out_xfer && s2_err && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign out_int32 = s2_data;
  assign out_err   = s2_err;
  assign err_cnt   = cnt;

endmodule
